// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC register with IF/ID capture,
// imem wait states, stall skid buffer and redirects.
module pc_fetch_unit #(
  parameter int unsigned     WORD     = 32,
  parameter logic [WORD-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [WORD-1:0] pc_plus4,
  input  logic            branch_taken,
  input  logic [WORD-1:0] branch_target,
  input  logic            jump,
  input  logic [WORD-1:0] jump_target,
  input  logic            stall,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic [WORD-1:0] pc_out,
  output logic            imem_req,
  output logic            if_id_valid,
  output logic [31:0]     if_id_instr,
  output logic [WORD-1:0] if_id_pc_plus4
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0]     instr;
    logic [WORD-1:0] pc4;
  } slot_t;

  localparam logic [WORD-1:0] ALIGN =
    {{(WORD-2){1'b1}}, 2'b00};

  state_t          state;
  state_t          state_n;
  logic [WORD-1:0] pc;
  logic [WORD-1:0] pc_n;
  logic            valid;
  logic            valid_n;
  slot_t           id;
  slot_t           id_n;
  slot_t           skid;
  slot_t           skid_n;
  logic            redirect;
  logic [WORD-1:0] target;
  logic [WORD-1:0] seq_pc;

  assign redirect = branch_taken | jump;
  assign target   = (branch_taken ? branch_target
                                  : jump_target) & ALIGN;
  assign seq_pc   = pc_plus4 & ALIGN;

  assign pc_out         = pc;
  assign imem_req       = (state == FETCH);
  assign if_id_valid    = valid;
  assign if_id_instr    = id.instr;
  assign if_id_pc_plus4 = id.pc4;

  // Next-state and next-datapath selection.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    valid_n = valid;
    id_n    = id;
    skid_n  = skid;
    unique case (state)
      BOOT: begin
        state_n = FETCH;
      end
      FETCH: begin
        if (redirect) begin
          pc_n    = target;
          valid_n = 1'b0;
          skid_n  = '0;
        end else if (imem_ready && !stall) begin
          valid_n = 1'b1;
          id_n    = '{instr: imem_rdata, pc4: pc_plus4};
          pc_n    = seq_pc;
        end else if (imem_ready) begin
          skid_n  = '{instr: imem_rdata, pc4: pc_plus4};
          state_n = HOLD;
        end else if (!stall) begin
          valid_n = 1'b0;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_n    = target;
          valid_n = 1'b0;
          skid_n  = '0;
          state_n = FETCH;
        end else if (!stall) begin
          valid_n = 1'b1;
          id_n    = skid;
          pc_n    = seq_pc;
          state_n = FETCH;
        end
      end
      default: begin
        state_n = BOOT;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
    end else begin
      state <= state_n;
    end
  end

  // PC, IF/ID and skid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      valid <= 1'b0;
      id    <= '0;
      skid  <= '0;
    end else begin
      pc    <= pc_n;
      valid <= valid_n;
      id    <= id_n;
      skid  <= skid_n;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed cases then
// random traffic against a behavioural model.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_plus4 = '0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic        stall = 1'b0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] pc_out;
  logic        imem_req;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;

  pc_fetch_unit #(
    .WORD(32),
    .RESET_PC(32'h0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pc_plus4(pc_plus4),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .jump(jump),
    .jump_target(jump_target),
    .stall(stall),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .pc_out(pc_out),
    .imem_req(imem_req),
    .if_id_valid(if_id_valid),
    .if_id_instr(if_id_instr),
    .if_id_pc_plus4(if_id_pc_plus4)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // model: pc, IF/ID, pending held instruction
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_started;
  logic        m_held;
  logic [31:0] h_instr;
  logic [31:0] h_pc4;

  function automatic logic [31:0] mem(
    input logic [31:0] a
  );
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc      = 32'h0;
    m_valid   = 1'b0;
    m_instr   = 32'h0;
    m_pc4     = 32'h0;
    m_started = 1'b0;
    m_held    = 1'b0;
    h_instr   = 32'h0;
    h_pc4     = 32'h0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"}, pc_out, m_pc);
    chk({tag, ".req"}, {31'b0, imem_req},
        {31'b0, m_started && !m_held});
    chk({tag, ".valid"}, {31'b0, if_id_valid},
        {31'b0, m_valid});
    chk({tag, ".instr"}, if_id_instr, m_instr);
    chk({tag, ".pc4"}, if_id_pc_plus4, m_pc4);
  endtask

  // one clock: drive at negedge, model at posedge,
  // compare at the following negedge
  task automatic step(
    input string       tag,
    input logic        br,
    input logic [31:0] bt,
    input logic        jp,
    input logic [31:0] jt,
    input logic        st,
    input logic        rdy
  );
    logic [31:0] a;
    a = m_pc;
    branch_taken  = br;
    branch_target = bt;
    jump          = jp;
    jump_target   = jt;
    stall         = st;
    imem_ready    = rdy;
    pc_plus4      = a + 32'd4;
    imem_rdata    = mem(a);
    @(posedge clk);
    if (!m_started) begin
      m_started = 1'b1;
    end else if (br || jp) begin
      m_pc    = (br ? bt : jt) & ~32'd3;
      m_valid = 1'b0;
      m_held  = 1'b0;
    end else if (m_held) begin
      if (!st) begin
        m_valid = 1'b1;
        m_instr = h_instr;
        m_pc4   = h_pc4;
        m_pc    = a + 32'd4;
        m_held  = 1'b0;
      end
    end else if (rdy && !st) begin
      m_valid = 1'b1;
      m_instr = mem(a);
      m_pc4   = a + 32'd4;
      m_pc    = a + 32'd4;
    end else if (rdy) begin
      m_held  = 1'b1;
      h_instr = mem(a);
      h_pc4   = a + 32'd4;
    end else if (!st) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    check_all("boot");

    // boot then first fetch
    step("t1a", 0, 0, 0, 0, 0, 1);
    step("t1b", 0, 0, 0, 0, 0, 1);
    chk("t1.instr", if_id_instr, mem(32'h0));
    chk("t1.pc", pc_out, 32'h4);

    // wait states at pc 8
    step("t2a", 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++)
      step("t2w", 0, 0, 0, 0, 0, 0);
    step("t2b", 0, 0, 0, 0, 0, 1);
    chk("t2.pc", pc_out, 32'hC);

    // stall with skid at pc 0x10
    step("t3a", 0, 0, 0, 0, 0, 1);
    step("t3s", 0, 0, 0, 0, 1, 1);
    step("t3s", 0, 0, 0, 0, 1, 1);
    step("t3r", 0, 0, 0, 0, 0, 1);
    chk("t3.instr", if_id_instr, mem(32'h10));
    chk("t3.pc", pc_out, 32'h14);

    // branch beats jump; jump target aligned
    step("t4a", 1, 32'h100, 1, 32'h203, 0, 1);
    chk("t4.pc", pc_out, 32'h100);
    step("t4b", 0, 0, 1, 32'h203, 0, 1);
    chk("t4.jpc", pc_out, 32'h200);

    // jump while holding drops the skid
    step("t5a", 0, 0, 0, 0, 0, 1);
    step("t5h", 0, 0, 0, 0, 1, 1);
    step("t5j", 0, 0, 1, 32'h40, 1, 1);
    chk("t5.pc", pc_out, 32'h40);
    step("t5f", 0, 0, 0, 0, 0, 1);
    chk("t5.instr", if_id_instr, mem(32'h40));

    // wrap at top of address space
    step("t6j", 0, 0, 1, 32'hFFFF_FFFC, 0, 1);
    step("t6w", 0, 0, 0, 0, 0, 1);
    chk("t6.wrap", pc_out, 32'h0);

    // async reset while waiting on memory
    step("t7w", 0, 0, 0, 0, 0, 0);
    step("t7w", 0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("areset");
    @(negedge clk);
    rst_n = 1'b1;
    // redirect during boot is ignored
    step("t8", 0, 0, 1, 32'h80, 0, 1);
    chk("t8.pc", pc_out, 32'h0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step("rnd",
           $urandom_range(0, 19) == 0,
           $urandom,
           $urandom_range(0, 19) == 0,
           $urandom,
           $urandom_range(0, 9) < 3,
           $urandom_range(0, 9) < 7);
    end

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
